// File: rtl/bfly_idx_pkg.sv
// Shared types and elaboration helpers for the butterfly index generator.
package bfly_idx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int idx_width(input int max_len);
    return $clog2(max_len);
  endfunction

  function automatic int stage_width(input int iw);
    return $clog2(iw + 1);
  endfunction

  // Legal N: nonzero power of two within [bu_par, max_len].
  function automatic logic len_legal(input int unsigned n, input int unsigned bu_par,
                                     input int unsigned max_len);
    return (n != 0) && ((n & (n - 1)) == 0) && (n >= bu_par) && (n <= max_len);
  endfunction

endpackage

// File: rtl/bfly_pair_addr.sv
// One butterfly lane: inserts a zero bit at position s of pair number j to form
// the top index a, and the bottom index b = a + 2^s.
module bfly_pair_addr #(
  parameter int IW = 12,
  parameter int SW = 4
) (
  input  logic [IW-1:0] j_i,
  input  logic [SW-1:0] s_i,
  output logic [IW-1:0] a_o,
  output logic [IW-1:0] b_o
);

  logic [IW-1:0] h;
  logic [IW-1:0] low;

  assign h   = IW'(1) << s_i;
  assign low = h - IW'(1);
  assign a_o = ((j_i & ~low) << 1) | (j_i & low);
  assign b_o = a_o | h;

endmodule

// File: rtl/bfly_idx_gen_flex.sv
// Butterfly (top, bottom) index pair generator with valid/ready output register.
// Define BFLY_IDX_DIT_EN to add the dit input (ascending stage order).
// State | meaning:  IDLE wait for start | RUN emit beats | DRAIN done pulse
module bfly_idx_gen_flex
  import bfly_idx_pkg::*;
#(
  parameter int  BU_PAR  = 8,
  parameter int  MAX_LEN = 4096,
  localparam int IW      = idx_width(MAX_LEN),
  localparam int SW      = stage_width(IW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IW:0]          length,
`ifdef BFLY_IDX_DIT_EN
  input  logic                 dit,
`endif
  input  logic                 abort,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [IW*BU_PAR-1:0] out_indx,
  output logic [SW-1:0]        out_stage,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int LB = $clog2(BU_PAR);
  localparam int NL = BU_PAR / 2;
  localparam logic [IW:0] LEN_ONE = 1;

  state_e                state_q;
  logic [SW-1:0]         stage_q, final_stage_q;
  logic [IW-1:0]         beat_q, beat_last_q;
  logic                  dit_q;
  logic                  out_vld_q, out_last_q, busy_q, done_q, err_q;
  logic [IW*BU_PAR-1:0]  out_indx_q;
  logic [SW-1:0]         out_stage_q;

  logic                  dit_in, legal_in;
  logic [SW-1:0]         log_in, first_stage_in, final_stage_in;
  logic [IW-1:0]         beat_last_in;
  logic                  beat_wrap, final_beat;
  logic [SW-1:0]         sel_stage;
  logic [IW-1:0]         sel_beat;
  logic                  sel_last;
  logic [IW*BU_PAR-1:0]  lanes_d;

`ifdef BFLY_IDX_DIT_EN
  assign dit_in = dit;
`else
  assign dit_in = 1'b0;
`endif

  always_comb begin
    log_in = '0;
    for (int i = 0; i <= IW; i++) begin
      if (length[i]) log_in = SW'(i);
    end
  end

  assign legal_in       = len_legal(32'(length), BU_PAR, MAX_LEN);
  assign beat_last_in   = IW'((length >> LB) - LEN_ONE);
  assign first_stage_in = dit_in ? '0 : log_in - SW'(1);
  assign final_stage_in = dit_in ? log_in - SW'(1) : '0;

  assign beat_wrap  = (beat_q == beat_last_q);
  assign final_beat = beat_wrap && (stage_q == final_stage_q);

  // In IDLE the lanes are precomputed for the first beat so it can load on start.
  always_comb begin
    sel_stage = stage_q;
    sel_beat  = beat_q + IW'(1);
    if (state_q == ST_IDLE) begin
      sel_stage = first_stage_in;
      sel_beat  = '0;
    end else if (beat_wrap) begin
      sel_beat  = '0;
      sel_stage = dit_q ? stage_q + SW'(1) : stage_q - SW'(1);
    end
    sel_last = (sel_beat == ((state_q == ST_IDLE) ? beat_last_in : beat_last_q));
  end

  for (genvar m = 0; m < NL; m++) begin : g_lane
    logic [IW-1:0] j, a, b;
    assign j = (sel_beat << (LB - 1)) | IW'(m);
    bfly_pair_addr #(.IW(IW), .SW(SW)) u_pair (
      .j_i (j),
      .s_i (sel_stage),
      .a_o (a),
      .b_o (b)
    );
    assign lanes_d[2*IW*m +: 2*IW] = {b, a};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      stage_q       <= '0;
      final_stage_q <= '0;
      beat_q        <= '0;
      beat_last_q   <= '0;
      dit_q         <= 1'b0;
      out_vld_q     <= 1'b0;
      out_indx_q    <= '0;
      out_stage_q   <= '0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q     <= ST_IDLE;
        out_vld_q   <= 1'b0;
        busy_q      <= 1'b0;
        out_indx_q  <= '0;
        out_stage_q <= '0;
        out_last_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (legal_in) begin
                state_q       <= ST_RUN;
                busy_q        <= 1'b1;
                out_vld_q     <= 1'b1;
                out_indx_q    <= lanes_d;
                out_stage_q   <= sel_stage;
                out_last_q    <= sel_last;
                stage_q       <= sel_stage;
                beat_q        <= sel_beat;
                beat_last_q   <= beat_last_in;
                final_stage_q <= final_stage_in;
                dit_q         <= dit_in;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            // out_vld_q is always set in RUN, so a handshake is the only load event.
            if (out_vld_q && out_rdy) begin
              if (final_beat) begin
                state_q   <= ST_DRAIN;
                out_vld_q <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
              end else begin
                out_indx_q  <= lanes_d;
                out_stage_q <= sel_stage;
                out_last_q  <= sel_last;
                stage_q     <= sel_stage;
                beat_q      <= sel_beat;
              end
            end
          end
          ST_DRAIN: state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_vld   = out_vld_q;
  assign out_indx  = out_indx_q;
  assign out_stage = out_stage_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bfly_idx_gen_flex.sv
// Directed bench for bfly_idx_gen_flex (BU_PAR=8, MAX_LEN=4096): hand-computed
// N=16 table, a pair-enumeration model for larger N, and multi-cycle corner cases.
module tb_bfly_idx_gen_flex;

  localparam int IW = 12;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW:0]   length = '0;
  logic          abort = 1'b0;
  logic          out_rdy = 1'b1;
  logic          out_vld, out_last, busy, done, err;
  logic [95:0]   out_indx;
  logic [SW-1:0] out_stage;
`ifdef BFLY_IDX_DIT_EN
  logic          dit_r = 1'b0;
`endif

  bfly_idx_gen_flex #(.BU_PAR(8), .MAX_LEN(4096)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .length    (length),
`ifdef BFLY_IDX_DIT_EN
    .dit       (dit_r),
`endif
    .abort     (abort),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_indx  (out_indx),
    .out_stage (out_stage),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  stage;
    logic        last;
    logic [95:0] indx;
  } vec_t;

  vec_t dif_tab[$];
  vec_t exp_q[$];
  vec_t got[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", nm, act, exp);
  endtask

  function automatic logic [95:0] pk(input int a0, b0, a1, b1, a2, b2, a3, b3);
    return {12'(b3), 12'(a3), 12'(b2), 12'(a2), 12'(b1), 12'(a1), 12'(b0), 12'(a0)};
  endfunction

  task automatic add(input int s, input logic l, input logic [95:0] x);
    vec_t v;
    v.stage = 4'(s);
    v.last  = l;
    v.indx  = x;
    dif_tab.push_back(v);
  endtask

  function automatic vec_t cap();
    vec_t v;
    v.stage = out_stage;
    v.last  = out_last;
    v.indx  = out_indx;
    return v;
  endfunction

  // Reference: list every top index with bit s clear, in ascending order; beat k
  // takes the pairs 4k..4k+3 of that list.
  task automatic build_model(input int n, input logic d);
    int lg, nb, s;
    int lst[$];
    vec_t v;
    exp_q.delete();
    lg = $clog2(n);
    nb = n / 8;
    for (int t = 0; t < lg; t++) begin
      s = d ? t : lg - 1 - t;
      lst.delete();
      for (int a = 0; a < n; a++) if (((a >> s) & 1) == 0) lst.push_back(a);
      for (int k = 0; k < nb; k++) begin
        v.stage = 4'(s);
        v.last  = (k == nb - 1);
        for (int m = 0; m < 4; m++) begin
          v.indx[24*m +: 12]      = 12'(lst[k*4+m]);
          v.indx[24*m + 12 +: 12] = 12'(lst[k*4+m] + (1 << s));
        end
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic cmp_seq(input string nm);
    chk_i({nm, "_beats"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk_v($sformatf("%s_beat%0d", nm, i), 128'(got[i]), 128'(exp_q[i]));
  endtask

  // Caller is at a negedge with start just accepted; drive start for one cycle.
  task automatic do_start(input int len);
    start  = 1'b1;
    length = len[IW:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collects beats until done; optional stall of stall_n cycles when beat stall_at
  // is presented. A start pulse mid-run must be ignored.
  task automatic run_collect(input string nm, input int stall_at, input int stall_n,
                             input int budget);
    int          stall_left = 0;
    logic        stalled = 1'b0;
    logic        saw = 1'b0;
    int          hs_c = -1;
    logic [95:0] held = '0;
    logic [3:0]  hstage = '0;
    got.delete();
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        saw = 1'b1;
        chk_i({nm, "_done_lat"}, c - hs_c, 1);
        chk_b({nm, "_busy_at_done"}, busy, 1'b0);
        chk_b({nm, "_vld_at_done"}, out_vld, 1'b0);
        break;
      end
      if (c == 1) begin
        start  = 1'b1;
        length = 13'd32;
      end else begin
        start = 1'b0;
      end
      if (!stalled && out_vld && got.size() == stall_at) begin
        stalled    = 1'b1;
        stall_left = stall_n;
        held       = out_indx;
        hstage     = out_stage;
      end
      if (stall_left > 0) begin
        out_rdy = 1'b0;
        if (stall_left < stall_n) begin
          chk_v({nm, "_stall_indx"}, 128'(out_indx), 128'(held));
          chk_i({nm, "_stall_stage"}, int'(out_stage), int'(hstage));
          chk_b({nm, "_stall_vld"}, out_vld, 1'b1);
        end
        stall_left--;
      end else begin
        out_rdy = 1'b1;
      end
      if (out_vld && out_rdy) begin
        got.push_back(cap());
        hs_c = c;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    out_rdy = 1'b1;
    chk_b({nm, "_done_seen"}, saw, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad[3];
    logic reached;
    vec_t fin;

    add(3, 1'b0, pk(0, 8, 1, 9, 2, 10, 3, 11));
    add(3, 1'b1, pk(4, 12, 5, 13, 6, 14, 7, 15));
    add(2, 1'b0, pk(0, 4, 1, 5, 2, 6, 3, 7));
    add(2, 1'b1, pk(8, 12, 9, 13, 10, 14, 11, 15));
    add(1, 1'b0, pk(0, 2, 1, 3, 4, 6, 5, 7));
    add(1, 1'b1, pk(8, 10, 9, 11, 12, 14, 13, 15));
    add(0, 1'b0, pk(0, 1, 2, 3, 4, 5, 6, 7));
    add(0, 1'b1, pk(8, 9, 10, 11, 12, 13, 14, 15));

    @(negedge clk);
    chk_v("reset_outputs", 128'({out_vld, busy, done, err, out_last, out_stage, out_indx}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_v("idle_outputs", 128'({out_vld, busy, done, err, out_last, out_stage, out_indx}), 128'(0));

    // N=16 against the hand table, full throughput
    do_start(16);
    chk_b("first_vld", out_vld, 1'b1);
    chk_b("first_busy", busy, 1'b1);
    run_collect("n16", -1, 0, 200);
    exp_q = dif_tab;
    cmp_seq("n16");

    // start during the done cycle is ignored; start in the next cycle is taken
    start  = 1'b1;
    length = 13'd32;
    @(negedge clk);
    chk_b("drain_ignore_busy", busy, 1'b0);
    chk_b("drain_ignore_vld", out_vld, 1'b0);
    do_start(16);
    chk_b("b2b_vld", out_vld, 1'b1);
    chk_i("b2b_stage", int'(out_stage), 3);
    run_collect("n16_stall", 3, 3, 200);
    cmp_seq("n16_stall");

    // illegal lengths (8192 does not fit in 13 bits and reads as 0)
    bad[0] = 100; bad[1] = 4; bad[2] = 8192;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      do_start(bad[i]);
      chk_b($sformatf("err_pulse_%0d", bad[i]), err, 1'b1);
      chk_b($sformatf("err_vld_%0d", bad[i]), out_vld, 1'b0);
      chk_b($sformatf("err_busy_%0d", bad[i]), busy, 1'b0);
      @(negedge clk);
      chk_b($sformatf("err_clear_%0d", bad[i]), err, 1'b0);
      chk_b($sformatf("err_busy2_%0d", bad[i]), busy, 1'b0);
    end
    do_start(128);
    run_collect("n128", -1, 0, 300);
    build_model(128, 1'b0);
    cmp_seq("n128");

    // smallest legal length: one beat per stage
    @(negedge clk);
    do_start(8);
    run_collect("n8", -1, 0, 50);
    build_model(8, 1'b0);
    cmp_seq("n8");

    // abort at beat 5 of N=64
    @(negedge clk);
    build_model(64, 1'b0);
    do_start(64);
    got.delete();
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      if (out_vld && got.size() == 5) begin
        abort = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        reached = 1'b1;
        chk_b("abort_vld", out_vld, 1'b0);
        chk_b("abort_busy", busy, 1'b0);
      end else begin
        if (out_vld && out_rdy) got.push_back(cap());
        @(negedge clk);
      end
    end
    chk_b("abort_reached", reached, 1'b1);
    chk_i("abort_beats", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk_v($sformatf("abort_beat%0d", i), 128'(got[i]), 128'(exp_q[i]));
    for (int c = 0; c < 4; c++) begin
      chk_b("abort_no_done", done, 1'b0);
      @(negedge clk);
    end

    // reset at beat 10 of a second N=64 run
    do_start(64);
    got.delete();
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      if (out_vld && got.size() == 10) begin
        rst_n = 1'b0;
        #1;
        reached = 1'b1;
        chk_v("rst_mid_outputs", 128'({out_vld, busy, done, err, out_last, out_stage, out_indx}), 128'(0));
      end else begin
        if (out_vld && out_rdy) got.push_back(cap());
        @(negedge clk);
      end
    end
    chk_b("rst_reached", reached, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_v("rst_after_outputs", 128'({out_vld, busy, done, err, out_last, out_stage, out_indx}), 128'(0));
    do_start(16);
    run_collect("n16_post_rst", -1, 0, 200);
    exp_q = dif_tab;
    cmp_seq("n16_post_rst");

    // largest length
    @(negedge clk);
    do_start(4096);
    run_collect("n4096", -1, 0, 7000);
    build_model(4096, 1'b0);
    cmp_seq("n4096");
    chk_i("n4096_count", got.size(), 6144);
    if (got.size() > 0) chk_i("n4096_first_stage", int'(got[0].stage), 11);
    fin.stage = 4'd0;
    fin.last  = 1'b1;
    fin.indx  = pk(4088, 4089, 4090, 4091, 4092, 4093, 4094, 4095);
    if (got.size() > 0) chk_v("n4096_final", 128'(got[got.size()-1]), 128'(fin));

`ifdef BFLY_IDX_DIT_EN
    @(negedge clk);
    exp_q.delete();
    for (int s = 0; s < 4; s++)
      foreach (dif_tab[i]) if (int'(dif_tab[i].stage) == s) exp_q.push_back(dif_tab[i]);
    dit_r = 1'b1;
    do_start(16);
    run_collect("dit16", -1, 0, 200);
    cmp_seq("dit16");
    dit_r = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
